// File: rtl/ram128x16_pkg.sv
// Shared widths, FSM encodings and requester IDs for the two-port
// arbiter in front of a 128x16 asynchronous SRAM.
package ram128x16_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the
// requester that was not granted last.
module rr_arb2
  import ram128x16_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_i,
  output logic grant_o
);

  always_comb begin
    grant_o = REQ_A;
    if (req_a_i && req_b_i) begin
      grant_o = ~last_i;
    end else if (req_b_i) begin
      grant_o = REQ_B;
    end
  end

endmodule

// File: rtl/ram128x16_arbiter.sv
// Arbitrates two requesters onto one asynchronous 128x16 SRAM using an
// IDLE/SETUP/STROBE/DONE access sequence.
module ram128x16_arbiter
  import ram128x16_pkg::*;
#(
  parameter int STROBE_CYC = 1
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              reqA,
  input  logic              weA,
  input  logic [ADDR_W-1:0] adrsA,
  input  logic [DATA_W-1:0] wdataA,
  output logic              ackA,
  output logic [DATA_W-1:0] rdataA,
  input  logic              reqB,
  input  logic              weB,
  input  logic [ADDR_W-1:0] adrsB,
  input  logic [DATA_W-1:0] wdataB,
  output logic              ackB,
  output logic [DATA_W-1:0] rdataB,
  output logic [ADDR_W-1:0] adrs,
  output logic [DATA_W-1:0] dataIn,
  output logic              _ce,
  output logic              _we,
  output logic              _oe,
  input  logic [DATA_W-1:0] dataOut,
  output logic              busy,
  output state_e            state_o
);

  // Handshake: reqX is a level held until ackX; ackX is a single-cycle pulse
  // in DONE. Requests are only sampled in IDLE, so a held req starts a new access.
  localparam logic [1:0] CNT_LAST = 2'(STROBE_CYC - 1);

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adrs_q, adrs_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
  logic                arb_grant;

  rr_arb2 u_rr_arb2 (
    .req_a_i (reqA),
    .req_b_i (reqB),
    .last_i  (last_q),
    .grant_o (arb_grant)
  );

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= REQ_B;
      we_q      <= 1'b0;
      adrs_q    <= '0;
      wdata_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      we_q      <= we_d;
      adrs_q    <= adrs_d;
      wdata_q   <= wdata_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // last_q doubles as the owner of the access in flight.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    we_d      = we_q;
    adrs_d    = adrs_q;
    wdata_d   = wdata_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    case (state_q)
      ST_IDLE: begin
        if (reqA || reqB) begin
          state_d = ST_SETUP;
          last_d  = arb_grant;
          if (arb_grant == REQ_A) begin
            we_d    = weA;
            adrs_d  = adrsA;
            wdata_d = wdataA;
          end else begin
            we_d    = weB;
            adrs_d  = adrsB;
            wdata_d = wdataB;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = '0;
      end
      ST_STROBE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          if (!we_q) begin
            if (last_q == REQ_A) rdata_a_d = dataOut;
            else                 rdata_b_d = dataOut;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    _ce  = (state_q == ST_IDLE);
    _we  = 1'b1;
    _oe  = 1'b1;
    ackA = 1'b0;
    ackB = 1'b0;
    busy = (state_q != ST_IDLE);
    if (state_q == ST_STROBE) begin
      _we = !we_q;
      _oe = we_q;
    end
    if (state_q == ST_DONE) begin
      ackA = (last_q == REQ_A);
      ackB = (last_q == REQ_B);
    end
  end

  // Write data brackets the _we pulse by one cycle on each side.
  assign dataIn  = (state_q != ST_IDLE && we_q) ? wdata_q : 'z;
  assign adrs    = adrs_q;
  assign rdataA  = rdata_a_q;
  assign rdataB  = rdata_b_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ram128x16_arbiter.sv
// Directed bench: one DUT with single-cycle strobe backed by a behavioural
// SRAM, and one with a four-cycle strobe whose read data is driven directly.
module tb_ram128x16_arbiter;
  import ram128x16_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic        req_a1 = 0, we_a1 = 0, req_b1 = 0, we_b1 = 0;
  logic [6:0]  adrs_a1 = 0, adrs_b1 = 0;
  logic [15:0] wdata_a1 = 0, wdata_b1 = 0;
  logic        ack_a1, ack_b1, ce1, we1, oe1, busy1;
  logic [15:0] rdata_a1, rdata_b1, data_out1;
  logic [6:0]  adrs1;
  tri1  [15:0] data_in1;
  state_e      state1;

  logic        req_a4 = 0;
  logic [6:0]  adrs_a4 = 0;
  logic [15:0] data_out4 = 0;
  logic        ack_a4, ack_b4, ce4, we4, oe4, busy4;
  logic [15:0] rdata_a4, rdata_b4;
  logic [6:0]  adrs4;
  tri1  [15:0] data_in4;
  state_e      state4;

  ram128x16_arbiter #(.STROBE_CYC(1)) u_dut1 (
    .clk(clk), ._rst(rst_n),
    .reqA(req_a1), .weA(we_a1), .adrsA(adrs_a1), .wdataA(wdata_a1),
    .ackA(ack_a1), .rdataA(rdata_a1),
    .reqB(req_b1), .weB(we_b1), .adrsB(adrs_b1), .wdataB(wdata_b1),
    .ackB(ack_b1), .rdataB(rdata_b1),
    .adrs(adrs1), .dataIn(data_in1), ._ce(ce1), ._we(we1), ._oe(oe1),
    .dataOut(data_out1), .busy(busy1), .state_o(state1)
  );

  ram128x16_arbiter #(.STROBE_CYC(4)) u_dut4 (
    .clk(clk), ._rst(rst_n),
    .reqA(req_a4), .weA(1'b0), .adrsA(adrs_a4), .wdataA(16'h0000),
    .ackA(ack_a4), .rdataA(rdata_a4),
    .reqB(1'b0), .weB(1'b0), .adrsB(7'h00), .wdataB(16'h0000),
    .ackB(ack_b4), .rdataB(rdata_b4),
    .adrs(adrs4), .dataIn(data_in4), ._ce(ce4), ._we(we4), ._oe(oe4),
    .dataOut(data_out4), .busy(busy4), .state_o(state4)
  );

  // Behavioural asynchronous SRAM: write lands on the rising edge of _we.
  logic [15:0] mem [128];
  always @(posedge we1) if (!ce1) mem[adrs1] = data_in1;
  assign data_out1 = (!ce1 && !oe1) ? mem[adrs1] : 16'h0000;

  logic both_ack1 = 1'b0;
  always @(negedge clk) if (ack_a1 && ack_b1) both_ack1 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access1(input logic use_b, input logic we, input logic [6:0] a,
                         input logic [15:0] d);
    logic got;
    got = 1'b0;
    if (!use_b) begin
      req_a1 = 1'b1; we_a1 = we; adrs_a1 = a; wdata_a1 = d;
    end else begin
      req_b1 = 1'b1; we_b1 = we; adrs_b1 = a; wdata_b1 = d;
    end
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      got = use_b ? ack_b1 : ack_a1;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    req_a1 = 1'b0;
    req_b1 = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic got;
    int   cyc;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state1, ST_IDLE);
    chk("rst_strobes", {ce1, we1, oe1}, 3'b111);
    chk("rst_acks", {ack_a1, ack_b1}, 2'b00);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_adrs", adrs1, 7'h00);
    chk("rst_datain", data_in1, 16'hFFFF);
    chk("rst_rdata", {rdata_a1, rdata_b1}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Four-cycle strobe read; read data changes every strobe cycle.
    req_a4 = 1'b1; adrs_a4 = 7'h12;
    tick();
    chk("s4_setup_oe", oe4, 1'b1);
    chk("s4_setup_ce", ce4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s4_strobe_oe", oe4, 1'b0);
      chk("s4_strobe_ack", ack_a4, 1'b0);
      data_out4 = {4{4'(k + 1)}};
    end
    tick();
    chk("s4_done_ack", ack_a4, 1'b1);
    chk("s4_done_rdata", rdata_a4, 16'h4444);
    chk("s4_done_oe", oe4, 1'b1);
    chk("s4_done_ackb", ack_b4, 1'b0);
    chk("s4_done_adrs", adrs4, 7'h12);
    req_a4 = 1'b0;
    tick();
    chk("s4_idle_ack", ack_a4, 1'b0);
    chk("s4_idle_busy", busy4, 1'b0);

    // Single A write of 16'h2684 to address 05, cycle by cycle.
    req_a1 = 1'b1; we_a1 = 1'b1; adrs_a1 = 7'h05; wdata_a1 = 16'h2684;
    tick();
    chk("wr_setup_strobes", {ce1, we1, oe1}, 3'b011);
    chk("wr_setup_adrs", adrs1, 7'h05);
    chk("wr_setup_datain", data_in1, 16'h2684);
    chk("wr_setup_busy", busy1, 1'b1);
    chk("wr_setup_state", state1, ST_SETUP);
    tick();
    chk("wr_strobe_strobes", {ce1, we1, oe1}, 3'b001);
    chk("wr_strobe_datain", data_in1, 16'h2684);
    chk("wr_strobe_ack", ack_a1, 1'b0);
    tick();
    chk("wr_done_acks", {ack_a1, ack_b1}, 2'b10);
    chk("wr_done_strobes", {ce1, we1, oe1}, 3'b011);
    chk("wr_done_datain", data_in1, 16'h2684);
    req_a1 = 1'b0;
    tick();
    chk("wr_idle_ce", ce1, 1'b1);
    chk("wr_idle_ack", ack_a1, 1'b0);
    chk("wr_idle_datain", data_in1, 16'hFFFF);
    chk("wr_idle_busy", busy1, 1'b0);
    access1(1'b0, 1'b0, 7'h05, 16'h0000);
    chk("rd_back_05", rdata_a1, 16'h2684);

    // B fills the whole array, then A reads it back.
    for (int i = 0; i < 128; i++) access1(1'b1, 1'b1, 7'(i), 16'(16'h2264 + i));
    chk("fill_rdata_b", rdata_b1, 16'h0000);
    chk("fill_rdata_a", rdata_a1, 16'h2684);
    for (int i = 0; i < 128; i++) begin
      access1(1'b0, 1'b0, 7'(i), 16'h0000);
      chk("sweep_rdata", rdata_a1, 16'h2264 + i);
    end
    chk("sweep_rdata_b", rdata_b1, 16'h0000);

    // Both requesters held from reset: grants alternate A,B,A,B.
    rst_n = 1'b0;
    req_a1 = 1'b1; we_a1 = 1'b0; adrs_a1 = 7'h10;
    req_b1 = 1'b1; we_b1 = 1'b0; adrs_b1 = 7'h20;
    tick();
    chk("rr_rst_rdata", rdata_a1, 16'h0000);
    chk("rr_rst_busy", busy1, 1'b0);
    both_ack1 = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        tick();
        cyc++;
        got = ack_a1 | ack_b1;
      end
      chk("rr_ack_a", ack_a1, (k % 2) == 0);
      chk("rr_ack_b", ack_b1, (k % 2) == 1);
      if ((k % 2) == 0) chk("rr_rdata_a", rdata_a1, 16'h2274);
      else              chk("rr_rdata_b", rdata_b1, 16'h2284);
    end
    chk("rr_cycles", cyc, 15);
    req_a1 = 1'b0;
    req_b1 = 1'b0;
    tick();
    chk("rr_no_double_ack", both_ack1, 1'b0);

    // Reset pulse during the strobe of a write aborts it immediately.
    req_a1 = 1'b1; we_a1 = 1'b1; adrs_a1 = 7'h30; wdata_a1 = 16'hBEEF;
    tick();
    tick();
    chk("ab_strobe_we", {ce1, we1}, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ab_async_strobes", {ce1, we1, oe1}, 3'b111);
    chk("ab_async_datain", data_in1, 16'hFFFF);
    chk("ab_async_ack", ack_a1, 1'b0);
    chk("ab_async_state", state1, ST_IDLE);
    req_a1 = 1'b0;
    tick();
    chk("ab_rst_ack", ack_a1, 1'b0);
    chk("ab_rst_adrs", adrs1, 7'h00);
    rst_n = 1'b1;
    tick();
    access1(1'b0, 1'b0, 7'h31, 16'h0000);
    chk("ab_next_read", rdata_a1, 16'h2295);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
